id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline boundary of the 5-stage MIPS core. Captures the main decoder's control bundle, register-file operands, extended immediate and register indices at the end of ID, and presents them to EX. Owns load-use hazard detection: it stalls PC and IF/ID and inserts a bubble. Also handles flush from branch/jump resolution and hold from a downstream stall.

## Interface
- Parameters
  - `W`, 32: datapath width.
- Ports
  - `clk`  in  1  rising-edge clock
  - `rst_n`  in  1  reset, synchronous, active-low
  - `id_valid`  in  1  ID holds a real instruction
  - `id_ctl`  in  13  {Bne, ExtOp, RegWrite, RegDst, AluSrc, Branch, MemWrite, MemToReg, Jump, AluOp[2:0], RType} from decoder
  - `id_rd1`, `id_rd2`  in  W  register-file read data
  - `id_imm16`  in  16  instruction[15:0]
  - `id_rs`, `id_rt`, `id_rd`  in  5  instruction register fields
  - `id_pc4`  in  W  PC+4 of the ID instruction
  - `flush`  in  1  kill the ID instruction (taken branch/jump resolved)
  - `ex_hold`  in  1  EX/MEM cannot advance; freeze this stage
  - `stall`  out  1  freeze PC and IF/ID this cycle
  - `ex_valid`  out  1  EX holds a real instruction
  - `ex_ctl`  out  13  registered control bundle
  - `ex_rd1`, `ex_rd2`, `ex_imm`, `ex_pc4`  out  W  registered operands
  - `ex_rs`, `ex_rt`, `ex_rd`  out  5  registered indices

## Operation
- Immediate: `ExtOp`=1 gives the sign-extended `id_imm16` to W. `ExtOp`=0 gives the zero-extended value.
- Source usage:
  - `rs_used` = ~Jump.
  - `rt_used` = RType | Branch | MemWrite.
- Load-use hazard: `lu` = ex_valid & ex_ctl.MemToReg & ex_rt≠0 & id_valid & ((rs_used & id_rs==ex_rt) | (rt_used & id_rt==ex_rt)).
- `stall` = (lu | ex_hold) & ~flush.
- Register update at each rising edge, in priority order:
  1. `rst_n`=0: every register is cleared to 0.
  2. `flush`=1: bubble.
  3. `ex_hold`=1: all registers keep their values.
  4. `lu`=1: bubble.
  5. Otherwise: capture every ID input, with ex_valid←id_valid.
- Bubble: ex_valid←0 and ex_ctl←0 (a NOP: no RegWrite, no MemWrite, no Branch/Jump). Data and index fields still load from ID.
- When id_valid=0, ex_ctl is captured as-is. Consumers must gate side effects with ex_valid.

## Timing
- Latency is 1 cycle from ID inputs to ex_* outputs.
- `stall` is combinational from the ID inputs and the EX registers. It has no registered delay.
- Reset value of every output is 0. `stall` evaluates to 0 after reset because ex_valid=0.
- During a load-use stall of exactly one cycle, IF/ID holds and EX receives a bubble. The next cycle, lu=0 because ex_valid=0, and the instruction advances.
- flush and lu in the same cycle: flush wins. stall=0 and a bubble is inserted.
- flush and ex_hold in the same cycle: flush wins. Upstream redirect owns the PC.
- ex_hold and lu in the same cycle: hold. stall=1 and the lu check is repeated next cycle.
- Reset asserted mid-stall clears the registers at the next edge. stall drops in the same cycle as ex_valid.

## Structure
- The shared package `mips_pkg` holds:
  - `CTL_W`=13
  - the bit-position constants for every ctl field
  - `CTL_NOP`=13'b0
  - the field-extraction functions used by the decoder and this stage
- Sub-module `hazard_detect` is combinational. It takes id_ctl, id_rs, id_rt, id_valid, ex_valid, ex_ctl.MemToReg and ex_rt, and outputs lu. It is reused when forwarding is added.
- The remaining logic is one always block for the registers plus the extension logic.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with arbitrary inputs. Required: all ex_* = 0 and stall=0. Release, present addi ($8←$9+0xFFFF) with ExtOp=1. Required one cycle later: ex_imm=0xFFFFFFFF, ex_ctl=0b0110_1000_0010_0.
- Zero-extend: present ori with imm 0x8001 and ExtOp=0. Required: ex_imm=0x00008001.
- Load-use: lw $5 in EX, then R-type with rs=$5 in ID. Required: stall=1 for exactly one cycle, then ex_valid=0 with ex_ctl=0. The next cycle captures the R-type. Repeat with rt=$0 loaded: no stall.
- rt-not-used: lw $5 in EX, addi with rt=$5 in ID. Required: no stall. Same case with sw using rt=$5: stall.
- Flush vs hazard: assert flush during a load-use cycle. Required: stall=0 and a bubble at the next edge.
- Hold: ex_hold=1 for 3 cycles while the ID inputs change. Required: ex_* unchanged and stall=1 throughout. Release: the current ID values are captured.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the 5-stage MIPS core: control-bundle width, the bit
// position of every decoder control field, the NOP bundle, and the small field
// extraction helpers used by the decoder and the ID/EX boundary.
//
// Control bundle layout, MSB to LSB:
//   {Bne, ExtOp, RegWrite, RegDst, AluSrc, Branch, MemWrite, MemToReg,
//    Jump, AluOp[2:0], RType}
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int CTL_W = 13;

    localparam int CTL_RTYPE    = 0;
    localparam int CTL_ALUOP_LO = 1;
    localparam int CTL_ALUOP_HI = 3;
    localparam int CTL_JUMP     = 4;
    localparam int CTL_MEMTOREG = 5;
    localparam int CTL_MEMWRITE = 6;
    localparam int CTL_BRANCH   = 7;
    localparam int CTL_ALUSRC   = 8;
    localparam int CTL_REGDST   = 9;
    localparam int CTL_REGWRITE = 10;
    localparam int CTL_EXTOP    = 11;
    localparam int CTL_BNE      = 12;

    typedef logic [CTL_W-1:0] ctl_vec_t;

    // All-zero bundle: no register write, no memory write, no control flow.
    localparam ctl_vec_t CTL_NOP = 13'b0;

    function automatic logic ctl_ext_op(input ctl_vec_t ctl);
        return ctl[CTL_EXTOP];
    endfunction

    function automatic logic ctl_mem_to_reg(input ctl_vec_t ctl);
        return ctl[CTL_MEMTOREG];
    endfunction

    function automatic logic ctl_reg_write(input ctl_vec_t ctl);
        return ctl[CTL_REGWRITE];
    endfunction

    function automatic logic [2:0] ctl_alu_op(input ctl_vec_t ctl);
        return ctl[CTL_ALUOP_HI:CTL_ALUOP_LO];
    endfunction

    // Every instruction except J/JAL reads rs.
    function automatic logic ctl_rs_used(input ctl_vec_t ctl);
        return ~ctl[CTL_JUMP];
    endfunction

    // rt is a source only for R-type ALU ops, branch compares and store data;
    // for I-type ALU ops and loads it is the destination.
    function automatic logic ctl_rt_used(input ctl_vec_t ctl);
        return ctl[CTL_RTYPE] | ctl[CTL_BRANCH] | ctl[CTL_MEMWRITE];
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use hazard detector. Flags an ID instruction that reads
// the register a load currently in EX will write, which cannot be forwarded
// in time and therefore needs a one-cycle bubble.
//
// Ports:
//   id_ctl        in  decoder control bundle of the ID instruction
//   id_rs, id_rt  in  ID source register indices
//   id_valid      in  ID holds a real instruction
//   ex_valid      in  EX holds a real instruction
//   ex_mem_to_reg in  EX instruction is a load
//   ex_rt         in  load destination register
//   lu            out load-use hazard present this cycle
// -----------------------------------------------------------------------------
module hazard_detect
    import mips_pkg::*;
(
    input  logic [CTL_W-1:0] id_ctl,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_valid,
    input  logic             ex_valid,
    input  logic             ex_mem_to_reg,
    input  logic [4:0]       ex_rt,
    output logic             lu
);

    logic load_in_ex_s;
    logic rs_hit_s;
    logic rt_hit_s;

    // A load to $0 never produces a value anyone waits on.
    always_comb begin
        load_in_ex_s = ex_valid & ex_mem_to_reg & (ex_rt != 5'd0);
        rs_hit_s     = ctl_rs_used(id_ctl) & (id_rs == ex_rt);
        rt_hit_s     = ctl_rt_used(id_ctl) & (id_rt == ex_rt);
        lu           = load_in_ex_s & id_valid & (rs_hit_s | rt_hit_s);
    end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// Decode-to-execute pipeline register. Captures control, operands, extended
// immediate, register indices and PC+4 at the end of ID. Detects load-use
// hazards (stalling PC and IF/ID while injecting a bubble), kills the ID
// instruction on flush and freezes on a downstream hold.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   id_valid, id_ctl      ID instruction valid and control bundle
//   id_rd1, id_rd2        register-file read data
//   id_imm16              raw 16-bit immediate
//   id_rs, id_rt, id_rd   register indices
//   id_pc4                PC+4 of the ID instruction
//   flush                 kill the ID instruction
//   ex_hold               EX/MEM cannot advance; freeze this stage
//   stall                 freeze PC and IF/ID (combinational)
//   ex_*                  registered EX-side copies
// -----------------------------------------------------------------------------
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [CTL_W-1:0] id_ctl,
    input  logic [W-1:0]     id_rd1,
    input  logic [W-1:0]     id_rd2,
    input  logic [15:0]      id_imm16,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic [W-1:0]     id_pc4,
    input  logic             flush,
    input  logic             ex_hold,
    output logic             stall,
    output logic             ex_valid,
    output logic [CTL_W-1:0] ex_ctl,
    output logic [W-1:0]     ex_rd1,
    output logic [W-1:0]     ex_rd2,
    output logic [W-1:0]     ex_imm,
    output logic [W-1:0]     ex_pc4,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd
);

    logic             lu_s;
    logic             load_s;
    logic             bubble_s;
    logic [W-1:0]     imm_ext_s;

    logic             ex_valid_r;
    logic [CTL_W-1:0] ex_ctl_r;
    logic [W-1:0]     ex_rd1_r;
    logic [W-1:0]     ex_rd2_r;
    logic [W-1:0]     ex_imm_r;
    logic [W-1:0]     ex_pc4_r;
    logic [4:0]       ex_rs_r;
    logic [4:0]       ex_rt_r;
    logic [4:0]       ex_rd_r;

    hazard_detect u_hazard_detect (
        .id_ctl        (id_ctl),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_valid      (id_valid),
        .ex_valid      (ex_valid_r),
        .ex_mem_to_reg (ctl_mem_to_reg(ex_ctl_r)),
        .ex_rt         (ex_rt_r),
        .lu            (lu_s)
    );

    // Sign- or zero-extend the immediate to datapath width.
    always_comb begin
        imm_ext_s = {W{1'b0}};
        if (ctl_ext_op(id_ctl)) begin
            imm_ext_s = {{(W-16){id_imm16[15]}}, id_imm16};
        end else begin
            imm_ext_s = {{(W-16){1'b0}}, id_imm16};
        end
    end

    // Flush overrides both hold and the hazard: the redirect owns the PC, so
    // nothing upstream should be frozen. A hold keeps IF/ID frozen as well.
    always_comb begin
        stall    = (lu_s | ex_hold) & ~flush;
        load_s   = flush | ~ex_hold;
        bubble_s = flush | lu_s;
    end

    // Pipeline register: reset, flush/hazard bubble, hold, or normal capture.
    // A bubble still loads data and index fields; only valid/ctl are killed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_r <= 1'b0;
            ex_ctl_r   <= CTL_NOP;
            ex_rd1_r   <= {W{1'b0}};
            ex_rd2_r   <= {W{1'b0}};
            ex_imm_r   <= {W{1'b0}};
            ex_pc4_r   <= {W{1'b0}};
            ex_rs_r    <= 5'd0;
            ex_rt_r    <= 5'd0;
            ex_rd_r    <= 5'd0;
        end else if (load_s) begin
            ex_valid_r <= id_valid & ~bubble_s;
            ex_ctl_r   <= bubble_s ? CTL_NOP : id_ctl;
            ex_rd1_r   <= id_rd1;
            ex_rd2_r   <= id_rd2;
            ex_imm_r   <= imm_ext_s;
            ex_pc4_r   <= id_pc4;
            ex_rs_r    <= id_rs;
            ex_rt_r    <= id_rt;
            ex_rd_r    <= id_rd;
        end
    end

    assign ex_valid = ex_valid_r;
    assign ex_ctl   = ex_ctl_r;
    assign ex_rd1   = ex_rd1_r;
    assign ex_rd2   = ex_rd2_r;
    assign ex_imm   = ex_imm_r;
    assign ex_pc4   = ex_pc4_r;
    assign ex_rs    = ex_rs_r;
    assign ex_rt    = ex_rt_r;
    assign ex_rd    = ex_rd_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all compared against a reference model kept in the bench.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int W = 32;

    // Control bundles written out field by field
    // {Bne,ExtOp,RegWrite,RegDst,AluSrc,Branch,MemWrite,MemToReg,Jump,AluOp,RType}
    localparam logic [12:0] C_ADDI  = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0};
    localparam logic [12:0] C_ORI   = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 1'b0};
    localparam logic [12:0] C_LW    = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0};
    localparam logic [12:0] C_SW    = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0};
    localparam logic [12:0] C_RTYPE = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 1'b1};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [12:0]   id_ctl;
    logic [W-1:0]  id_rd1, id_rd2, id_pc4;
    logic [15:0]   id_imm16;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic          flush, ex_hold;
    logic          stall, ex_valid;
    logic [12:0]   ex_ctl;
    logic [W-1:0]  ex_rd1, ex_rd2, ex_imm, ex_pc4;
    logic [4:0]    ex_rs, ex_rt, ex_rd;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the EX-side state
    typedef struct {
        logic        v;
        logic [12:0] ctl;
        logic [31:0] rd1, rd2, imm, pc4;
        logic [4:0]  rs, rt, rd;
    } ex_state_t;

    ex_state_t m;
    ex_state_t nxt;
    ex_state_t saved;

    always #5 clk = ~clk;

    id_ex_stage #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctl(id_ctl),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm16(id_imm16),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_pc4(id_pc4),
        .flush(flush), .ex_hold(ex_hold), .stall(stall),
        .ex_valid(ex_valid), .ex_ctl(ex_ctl), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Does the ID instruction read the register the EX load is writing?
    function automatic logic model_lu();
        logic reads_rs, reads_rt, is_load;
        reads_rs = (id_ctl[4] == 1'b0);
        reads_rt = id_ctl[0] || id_ctl[7] || id_ctl[6];
        is_load  = m.v && m.ctl[5] && (m.rt != 5'd0);
        return is_load && id_valid &&
               ((reads_rs && id_rs == m.rt) || (reads_rt && id_rt == m.rt));
    endfunction

    function automatic logic [31:0] model_imm();
        logic [31:0] v;
        v = {16'h0000, id_imm16};
        if (id_ctl[11] && v >= 32'd32768) v = v + 32'hFFFF_0000;
        return v;
    endfunction

    // One clock: check stall before the edge, advance the model, check after.
    task automatic step();
        logic lu;
        @(negedge clk);
        lu = model_lu();
        check_val("stall", {63'd0, stall}, {63'd0, (lu || ex_hold) && !flush});
        nxt = m;
        if (!rst_n) begin
            nxt = '{v: 1'b0, ctl: 13'd0, rd1: 32'd0, rd2: 32'd0, imm: 32'd0,
                    pc4: 32'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0};
        end else if (flush || !ex_hold) begin
            nxt = '{v: id_valid, ctl: id_ctl, rd1: id_rd1, rd2: id_rd2, imm: model_imm(),
                    pc4: id_pc4, rs: id_rs, rt: id_rt, rd: id_rd};
            if (flush || lu) begin
                nxt.v   = 1'b0;
                nxt.ctl = 13'd0;
            end
        end
        @(posedge clk);
        m = nxt;
        #1;
        check_val("ex_valid", {63'd0, ex_valid}, {63'd0, m.v});
        check_val("ex_ctl", {51'd0, ex_ctl}, {51'd0, m.ctl});
        check_val("ex_rd1", {32'd0, ex_rd1}, {32'd0, m.rd1});
        check_val("ex_rd2", {32'd0, ex_rd2}, {32'd0, m.rd2});
        check_val("ex_imm", {32'd0, ex_imm}, {32'd0, m.imm});
        check_val("ex_pc4", {32'd0, ex_pc4}, {32'd0, m.pc4});
        check_val("ex_idx", {49'd0, ex_rs, ex_rt, ex_rd}, {49'd0, m.rs, m.rt, m.rd});
    endtask

    task automatic set_id(input logic v, input logic [12:0] c, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm);
        id_valid = v;
        id_ctl   = c;
        id_rs    = rs;
        id_rt    = rt;
        id_rd    = rd;
        id_imm16 = imm;
        id_rd1   = $urandom;
        id_rd2   = $urandom;
        id_pc4   = $urandom;
    endtask

    initial begin
        m = '{v: 1'b0, ctl: 13'd0, rd1: 32'd0, rd2: 32'd0, imm: 32'd0,
              pc4: 32'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0};
        rst_n   = 1'b0;
        flush   = 1'b0;
        ex_hold = 1'b0;
        set_id(1'b1, C_LW, 5'd3, 5'd3, 5'd4, 16'h1234);
        @(posedge clk);
        #1;

        // Reset held for two cycles with arbitrary inputs
        for (int i = 0; i < 2; i++) begin
            set_id(1'b1, 13'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
            step();
        end
        check_val("rst_valid", {63'd0, ex_valid}, 64'd0);
        check_val("rst_stall", {63'd0, stall}, 64'd0);

        // addi $8 <- $9 + 0xFFFF, sign-extended
        rst_n = 1'b1;
        set_id(1'b1, C_ADDI, 5'd9, 5'd8, 5'd0, 16'hFFFF);
        step();
        check_val("addi_imm", {32'd0, ex_imm}, 64'h0000_0000_FFFF_FFFF);
        check_val("addi_ctl", {51'd0, ex_ctl}, {51'd0, 13'b0110_1000_0010_0});

        // ori with zero extension
        set_id(1'b1, C_ORI, 5'd2, 5'd3, 5'd0, 16'h8001);
        step();
        check_val("ori_imm", {32'd0, ex_imm}, 64'h0000_0000_0000_8001);

        // lw $5 then R-type reading $5 through rs
        set_id(1'b1, C_LW, 5'd1, 5'd5, 5'd0, 16'h0010);
        step();
        set_id(1'b1, C_RTYPE, 5'd5, 5'd6, 5'd7, 16'h3820);
        #1 check_val("lu_stall", {63'd0, stall}, 64'd1);
        step();
        check_val("lu_bubble_v", {63'd0, ex_valid}, 64'd0);
        check_val("lu_bubble_c", {51'd0, ex_ctl}, 64'd0);
        #1 check_val("lu_stall_drop", {63'd0, stall}, 64'd0);
        step();
        check_val("lu_adv_ctl", {51'd0, ex_ctl}, {51'd0, C_RTYPE});
        check_val("lu_adv_v", {63'd0, ex_valid}, 64'd1);

        // Load into $0 never stalls
        set_id(1'b1, C_LW, 5'd1, 5'd0, 5'd0, 16'h0004);
        step();
        set_id(1'b1, C_RTYPE, 5'd0, 5'd0, 5'd7, 16'h3820);
        #1 check_val("lu_r0", {63'd0, stall}, 64'd0);
        step();

        // addi writes rt (no stall); sw reads rt (stall)
        set_id(1'b1, C_LW, 5'd1, 5'd5, 5'd0, 16'h0008);
        step();
        set_id(1'b1, C_ADDI, 5'd3, 5'd5, 5'd0, 16'h0001);
        #1 check_val("addi_rt_free", {63'd0, stall}, 64'd0);
        set_id(1'b1, C_SW, 5'd3, 5'd5, 5'd0, 16'h0001);
        #1 check_val("sw_rt_stall", {63'd0, stall}, 64'd1);
        step();

        // Flush during a load-use cycle
        set_id(1'b1, C_LW, 5'd1, 5'd5, 5'd0, 16'h0008);
        step();
        set_id(1'b1, C_RTYPE, 5'd5, 5'd6, 5'd7, 16'h0000);
        flush = 1'b1;
        #1 check_val("flush_stall", {63'd0, stall}, 64'd0);
        step();
        flush = 1'b0;
        check_val("flush_bubble", {63'd0, ex_valid}, 64'd0);

        // Hold for three cycles while ID changes
        set_id(1'b1, C_ADDI, 5'd2, 5'd4, 5'd0, 16'h0042);
        step();
        saved = m;
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, C_RTYPE, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
            #1 check_val("hold_stall", {63'd0, stall}, 64'd1);
            step();
            check_val("hold_rd1", {32'd0, ex_rd1}, {32'd0, saved.rd1});
        end
        ex_hold = 1'b0;
        set_id(1'b1, C_ORI, 5'd9, 5'd10, 5'd0, 16'h5555);
        step();
        check_val("hold_release", {32'd0, ex_rd1}, {32'd0, id_rd1});

        // Random traffic with small register indices to provoke hazards
        for (int i = 0; i < 400; i++) begin
            logic [12:0] c;
            rst_n   = ($urandom_range(0, 49) != 0);
            flush   = ($urandom_range(0, 7) == 0);
            ex_hold = ($urandom_range(0, 5) == 0);
            c = 13'($urandom);
            if ($urandom_range(0, 1) == 1) c[5] = 1'b1;
            set_id($urandom_range(0, 3) != 0, c, 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom), 16'($urandom));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
